// File: rtl/mac_dot_sequencer.sv
// Sequencer for a two-lane 8-bit MAC (acc += a*b + c*d) fed from a synchronous operand RAM.
// Optional build macro MAC_SEQ_SATURATE_EN: saturate the accumulator and raise a sticky ovf.
module mac_dot_sequencer #(
    parameter int ADDR_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_a,
    input  logic [7:0]        rd_b,
    input  logic [7:0]        rd_c,
    input  logic [7:0]        rd_d,
    output logic [ACC_W-1:0]  result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              ovf
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

`ifdef MAC_SEQ_SATURATE_EN
    localparam int SUM_W = ACC_W + 1;
`else
    localparam int SUM_W = ACC_W;
`endif

    state_t            state;
    logic [ADDR_W-1:0] len_q;
    logic [ACC_W-1:0]  acc;
    logic              data_valid;
    logic [15:0]       prod_ab;
    logic [15:0]       prod_cd;
    logic [SUM_W-1:0]  acc_sum;
    logic [ACC_W-1:0]  acc_next;

    // Both products are at most 16 bits, so their sum plus acc carries out by at most one bit.
    always_comb begin
        prod_ab = {8'd0, rd_a} * {8'd0, rd_b};
        prod_cd = {8'd0, rd_c} * {8'd0, rd_d};
        acc_sum = {{(SUM_W-ACC_W){1'b0}}, acc}
                + {{(SUM_W-16){1'b0}}, prod_ab}
                + {{(SUM_W-16){1'b0}}, prod_cd};
    end

`ifdef MAC_SEQ_SATURATE_EN
    assign acc_next = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
`else
    assign acc_next = acc_sum;
    assign ovf      = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            rd_en        <= 1'b0;
            rd_addr      <= '0;
            len_q        <= '0;
            acc          <= '0;
            data_valid   <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
`ifdef MAC_SEQ_SATURATE_EN
            ovf          <= 1'b0;
`endif
        end else begin
            // Read data is qualified by the enable issued one cycle earlier.
            data_valid <= rd_en;
            if (data_valid) begin
                acc <= acc_next;
`ifdef MAC_SEQ_SATURATE_EN
                if (acc_sum[ACC_W]) begin
                    ovf <= 1'b1;
                end
`endif
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        acc  <= '0;
                        busy <= 1'b1;
`ifdef MAC_SEQ_SATURATE_EN
                        ovf  <= 1'b0;
`endif
                        if (len != '0) begin
                            len_q   <= len;
                            rd_addr <= '0;
                            rd_en   <= 1'b1;
                            state   <= RUN;
                        end else begin
                            result       <= '0;
                            result_valid <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end

                RUN: begin
                    if (rd_addr == len_q - ADDR_W'(1)) begin
                        rd_en <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end

                // Stay until the last returned entry has been folded into acc.
                DRAIN: begin
                    if (!data_valid) begin
                        result       <= acc;
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end
                end

                DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Self-checking bench for mac_dot_sequencer: operand RAM model, table-driven commands and reset abort.
module tb_mac_dot_sequencer;

    localparam int ADDR_W = 16;
    localparam int ACC_W  = 32;
    localparam longint unsigned ACC_MAX = (64'd1 << ACC_W) - 64'd1;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] len = '0;
    logic              busy;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_a, rd_b, rd_c, rd_d;
    logic [ACC_W-1:0]  result;
    logic              result_valid;
    logic              result_ready = 1'b0;
    logic              ovf;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_a [0:65535];
    logic [7:0] mem_b [0:65535];
    logic [7:0] mem_c [0:65535];
    logic [7:0] mem_d [0:65535];

    mac_dot_sequencer #(.ADDR_W(ADDR_W), .ACC_W(ACC_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .len          (len),
        .busy         (busy),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_a         (rd_a),
        .rd_b         (rd_b),
        .rd_c         (rd_c),
        .rd_d         (rd_d),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .ovf          (ovf)
    );

    always #5 clock = ~clock;

    // Synchronous RAM: data one cycle after rd_en, junk otherwise so stray accumulates show up.
    always @(posedge clock) begin
        if (rd_en) begin
            rd_a <= mem_a[rd_addr];
            rd_b <= mem_b[rd_addr];
            rd_c <= mem_c[rd_addr];
            rd_d <= mem_d[rd_addr];
        end else begin
            rd_a <= 8'($urandom);
            rd_b <= 8'($urandom);
            rd_c <= 8'($urandom);
            rd_d <= 8'($urandom);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        int              len;
        int              pattern;
        int              ready_delay;
        longint unsigned exp_result;
        bit              exp_ovf;
        bit              use_model;
    } vec_t;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // pattern 0: directed entries, 1: all operands 255, 2: random operands
    task automatic loadPattern(input int pattern);
        if (pattern == 0) begin
            mem_a[0] = 8'd10; mem_b[0] = 8'd20;  mem_c[0] = 8'd12;  mem_d[0] = 8'd5;
            mem_a[1] = 8'd20; mem_b[1] = 8'd30;  mem_c[1] = 8'd112; mem_d[1] = 8'd50;
            mem_a[2] = 8'd55; mem_b[2] = 8'd55;  mem_c[2] = 8'd55;  mem_d[2] = 8'd55;
            mem_a[3] = 8'd20; mem_b[3] = 8'd21;  mem_c[3] = 8'd90;  mem_d[3] = 8'd54;
        end else if (pattern == 1) begin
            for (int i = 0; i < 65536; i++) begin
                mem_a[i] = 8'hFF; mem_b[i] = 8'hFF; mem_c[i] = 8'hFF; mem_d[i] = 8'hFF;
            end
        end else begin
            for (int i = 0; i < 64; i++) begin
                mem_a[i] = 8'($urandom); mem_b[i] = 8'($urandom);
                mem_c[i] = 8'($urandom); mem_d[i] = 8'($urandom);
            end
        end
    endtask

    // Reference: exact dot product, then wrap or clamp at the accumulator width.
    task automatic modelResult(input int n, output longint unsigned exp_res, output bit exp_ovf);
        longint unsigned sum = 0;
        for (int i = 0; i < n; i++) begin
            sum += longint'(mem_a[i]) * longint'(mem_b[i]) + longint'(mem_c[i]) * longint'(mem_d[i]);
        end
`ifdef MAC_SEQ_SATURATE_EN
        exp_ovf = (sum > ACC_MAX);
        exp_res = exp_ovf ? ACC_MAX : sum;
`else
        exp_ovf = 1'b0;
        exp_res = sum & ACC_MAX;
`endif
    endtask

    // Issue one command, check the read stream and latency, then hold off ready and complete the handshake.
    task automatic applyStimulus(input int n, input int ready_delay,
                                 output logic [ACC_W-1:0] got, output logic got_ovf);
        int k = 0;
        int rd_cnt = 0;
        int seq_err = 0;
        int hold_err = 0;
        bit seen = 0;
        @(negedge clock);
        start = 1'b1;
        len = ADDR_W'(n);
        result_ready = 1'b0;
        @(posedge clock);
        while (k <= n + 10 && !seen) begin
            @(negedge clock);
            if (k == 0) checkOutput("busy_after_start", busy, 1);
            if (rd_en) begin
                rd_cnt++;
                if (rd_addr != ADDR_W'(k)) seq_err++;
            end
            if (result_valid) begin
                seen = 1;
                start = 1'b0;
            end else begin
                k++;
                start = 1'($urandom_range(0, 1));
                len = ADDR_W'($urandom);
            end
        end
        checkOutput("latency", seen ? k : -1, (n == 0) ? 0 : n + 2);
        checkOutput("rd_count", rd_cnt, n);
        checkOutput("rd_seq", seq_err, 0);
        got = result;
        got_ovf = ovf;
        for (int i = 0; i < ready_delay; i++) begin
            start = 1'b1;
            len = 16'd3;
            @(negedge clock);
            if (!result_valid || result != got || ovf != got_ovf || !busy) hold_err++;
        end
        if (ready_delay > 0) checkOutput("hold_in_done", hold_err, 0);
        start = 1'b0;
        result_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        result_ready = 1'b0;
        checkOutput("valid_drop", result_valid, 0);
        checkOutput("busy_drop", busy, 0);
        checkOutput("result_kept", result, got);
    endtask

    vec_t vecs[$];

    initial begin
        logic [ACC_W-1:0] got;
        logic             got_ovf;
        longint unsigned  exp_res;
        bit               exp_ovf;

        vecs.push_back('{1,  0, 0, 64'd260,   1'b0, 1'b0});
        vecs.push_back('{4,  0, 5, 64'd17790, 1'b0, 1'b0});
        vecs.push_back('{0,  0, 2, 64'd0,     1'b0, 1'b0});
        vecs.push_back('{7,  2, 1, 64'd0,     1'b0, 1'b1});
        vecs.push_back('{13, 2, 0, 64'd0,     1'b0, 1'b1});
        vecs.push_back('{1,  2, 3, 64'd0,     1'b0, 1'b1});
        vecs.push_back('{40, 2, 2, 64'd0,     1'b0, 1'b1});
        vecs.push_back('{2,  2, 0, 64'd0,     1'b0, 1'b1});
`ifdef MAC_SEQ_SATURATE_EN
        vecs.push_back('{65535, 1, 1, 64'hFFFF_FFFF, 1'b1, 1'b0});
`else
        vecs.push_back('{65535, 1, 1, 64'd4227859454, 1'b0, 1'b0});
`endif

        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_rd_en", rd_en, 0);
        checkOutput("reset_rd_addr", rd_addr, 0);
        checkOutput("reset_result", result, 0);
        checkOutput("reset_valid", result_valid, 0);
        checkOutput("reset_ovf", ovf, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        foreach (vecs[v]) begin
            loadPattern(vecs[v].pattern);
            if (vecs[v].use_model) begin
                modelResult(vecs[v].len, exp_res, exp_ovf);
            end else begin
                exp_res = vecs[v].exp_result;
                exp_ovf = vecs[v].exp_ovf;
            end
            applyStimulus(vecs[v].len, vecs[v].ready_delay, got, got_ovf);
            checkOutput($sformatf("result_len%0d", vecs[v].len), got, longint'(exp_res));
            checkOutput($sformatf("ovf_len%0d", vecs[v].len), got_ovf, exp_ovf);
        end

        // Abort a len=4 command mid-read, then prove the next command starts from a clean acc.
        loadPattern(0);
        @(negedge clock);
        start = 1'b1;
        len = 16'd4;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        checkOutput("mid_run_rd_en", rd_en, 1);
        reset = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_rd_en", rd_en, 0);
        checkOutput("abort_rd_addr", rd_addr, 0);
        checkOutput("abort_result", result, 0);
        checkOutput("abort_valid", result_valid, 0);
        checkOutput("abort_ovf", ovf, 0);
        @(negedge clock);
        reset = 1'b1;
        applyStimulus(1, 0, got, got_ovf);
        checkOutput("after_abort_result", got, 260);
        checkOutput("after_abort_ovf", got_ovf, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
